// File: rtl/sensor_request_scheduler_pkg.sv
// sensor_sched_pkg: shared states, response status codes and decoder command codes
package sensor_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_BUSY, ST_RESPOND} state_t;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] TIMEOUT = 2'b01;
  localparam logic [1:0] UNSUPPORTED = 2'b10;
  localparam logic [1:0] SENSOR_ERROR = 2'b11;
  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_MAX_ONESHOT = 8'h04;
  localparam logic [7:0] ERR_CODE = 8'h10;
endpackage

// File: rtl/sensor_request_scheduler_if.sv
// sensor_request_scheduler_if: requester command/response bundle
interface sensor_request_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = 5
);
  logic [NUM_REQ-1:0] valid;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*8-1:0] command;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  modport master(output valid, addr, command, input ready, rsp_valid, rsp_data, rsp_status);
  modport slave(input valid, addr, command, output ready, rsp_valid, rsp_data, rsp_status);
endinterface

// File: rtl/sensor_request_scheduler_arbiter.sv
// rr_arbiter: picks the first active request at or after the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IDW = $clog2(NUM_REQ);
  always_comb begin
    idx = '0;
    // scan from the far end so the lowest offset from ptr is written last
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) idx = IDW'((int'(ptr) + k) % NUM_REQ);
    end
    grant = |req ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/sensor_request_scheduler.sv
// sensor_request_scheduler: serialises one-shot sensor reads onto a single decoder
module sensor_request_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = 5,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int MIN_GAP_CYCLES = 100_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  sensor_request_scheduler_if.slave  req_if,
  output logic                       decoder_fault,
  output logic                       dec_enable,
  output logic [31:0]                dec_device_selector,
  output logic [7:0]                 dec_request,
  input  logic [7:0]                 dec_requested_data,
  input  logic                       dec_finished
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int GW = $clog2(MIN_GAP_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_d;
  logic [NUM_REQ-1:0] grant, rsp_valid;
  logic [IDW-1:0] gidx, id, rr;
  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wd_cnt;
  logic [7:0] cmd, sel_cmd, rsp_data;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0] rsp_status, status_d;
  logic accept, unsup, gap_ok, expire, leave_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) arb (
    .req(req_if.valid),
    .ptr(rr),
    .grant(grant),
    .idx(gidx)
  );

  assign req_if.ready = state == ST_IDLE ? grant : '0;
  assign req_if.rsp_valid = rsp_valid;
  assign req_if.rsp_data = rsp_data;
  assign req_if.rsp_status = rsp_status;
  assign accept = |(req_if.valid & req_if.ready);
  assign sel_cmd = req_if.command[8*gidx +: 8];
  assign sel_addr = req_if.addr[ADDR_W*gidx +: ADDR_W];
  assign unsup = sel_cmd > CMD_MAX_ONESHOT;
  assign gap_ok = gap_cnt >= GW'(MIN_GAP_CYCLES);
  assign expire = wd_cnt == WW'(TIMEOUT_CYCLES - 1);
  assign leave_busy = state == ST_BUSY && state_d == ST_RESPOND;
  // a completion always wins over the watchdog in the same cycle
  assign status_d = dec_finished ? ((cmd == CMD_STATUS && dec_requested_data == ERR_CODE) ? SENSOR_ERROR : OK) : TIMEOUT;

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: state_d = accept ? (unsup ? ST_RESPOND : ST_GAP) : ST_IDLE;
      ST_GAP: state_d = gap_ok ? ST_BUSY : ST_GAP;
      ST_BUSY: state_d = (dec_finished || expire) ? ST_RESPOND : ST_BUSY;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      rr <= '0;
      id <= '0;
      cmd <= '0;
      gap_cnt <= GW'(MIN_GAP_CYCLES);
      wd_cnt <= '0;
      dec_enable <= 1'b0;
      dec_device_selector <= '0;
      dec_request <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_status <= '0;
      decoder_fault <= 1'b0;
    end else begin
      state <= state_d;
      gap_cnt <= leave_busy ? '0 : gap_ok ? gap_cnt : gap_cnt + 1'b1;
      wd_cnt <= state == ST_BUSY ? wd_cnt + 1'b1 : '0;
      rsp_valid <= '0;
      if (accept) begin
        id <= gidx;
        cmd <= sel_cmd;
        if (unsup) begin
          rsp_valid <= grant;
          rsp_data <= '0;
          rsp_status <= UNSUPPORTED;
        end else begin
          dec_device_selector <= 32'(1) << sel_addr;
          dec_request <= sel_cmd;
        end
      end
      if (state == ST_GAP && gap_ok) dec_enable <= 1'b1;
      if (leave_busy) begin
        dec_enable <= 1'b0;
        rsp_valid <= NUM_REQ'(1) << id;
        rsp_data <= dec_finished ? dec_requested_data : '0;
        rsp_status <= status_d;
        decoder_fault <= !dec_finished || (decoder_fault && status_d != OK);
      end
      if (state == ST_RESPOND) rr <= id == IDW'(NUM_REQ - 1) ? '0 : id + 1'b1;
    end
  end
endmodule
